// File: rtl/vedic_pkg.sv
// Shared constants and types for the Vedic multiplier family.
// The 2-bit leaf cell and the wider 4/8/16-bit stages all size their
// operands and products from here.
package vedic_pkg;

  localparam int VEDIC_OP_W   = 2;
  localparam int VEDIC_PROD_W = 4;

  typedef logic [VEDIC_OP_W-1:0]   vedic_op_t;
  typedef logic [VEDIC_PROD_W-1:0] vedic_prod_t;

endpackage : vedic_pkg

// File: rtl/vedic_half_adder.sv
// Single-bit half adder used to combine the crosswise partial products.
// The wider Vedic stages reuse this same cell.
module vedic_half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);

  assign s  = x ^ y;
  assign co = x & y;

endmodule : vedic_half_adder

// File: rtl/vedic_2bit.sv
// 2x2-bit unsigned Urdhva-Tiryagbhyam multiplier with one register stage.
// Four AND partial products feed two half adders; the 4-bit product and a
// valid strobe are registered on the sampling edge (latency 1, one result
// per cycle, no backpressure).
// Optional build macro VEDIC_CHECK_EN adds output err, which flags any
// disagreement between the structural product and a behavioural multiply.
module vedic_2bit
  import vedic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [VEDIC_OP_W-1:0]   a,
  input  logic [VEDIC_OP_W-1:0]   b,
  output logic                    out_valid,
  output logic [VEDIC_PROD_W-1:0] c
`ifdef VEDIC_CHECK_EN
  ,
  output logic                    err
`endif
);

  // Vertical and crosswise partial products.
  logic w_q0, w_q1, w_q2, w_q3;
  // Half-adder outputs and assembled product bits.
  logic w_p0, w_p1, w_p2, w_p3, w_k;
  vedic_prod_t w_prod;

  assign w_q0 = a[0] & b[0];
  assign w_q1 = a[1] & b[0];
  assign w_q2 = a[0] & b[1];
  assign w_q3 = a[1] & b[1];

  // Bit 0 is the rightmost vertical product with nothing to add.
  assign w_p0 = w_q0;

  // HA1: the two crosswise products form bit 1 and a carry into bit 2.
  vedic_half_adder u_ha1 (
    .x  (w_q1),
    .y  (w_q2),
    .s  (w_p1),
    .co (w_k)
  );

  // HA2: the leftmost vertical product absorbs the crosswise carry.
  vedic_half_adder u_ha2 (
    .x  (w_q3),
    .y  (w_k),
    .s  (w_p2),
    .co (w_p3)
  );

  assign w_prod = {w_p3, w_p2, w_p1, w_p0};

  // Product register: capture on in_valid, hold otherwise; valid is a
  // one-cycle strobe per accepted operand pair.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register sees
    // the pre-edge values of its inputs, independent of statement order.
    if (rst) begin
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c <= w_prod;
      end
    end
  end

`ifdef VEDIC_CHECK_EN
  // Behavioural reference, widened so the multiply keeps all four bits.
  vedic_prod_t w_ref;
  assign w_ref = vedic_prod_t'(a) * vedic_prod_t'(b);

  // Self-check flag, aligned with out_valid; cleared whenever no sample is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (in_valid) begin
      err <= (w_prod != w_ref);
    end else begin
      err <= 1'b0;
    end
  end
`endif

endmodule : vedic_2bit

// File: tb/tb_vedic_2bit.sv
// Directed, table-driven bench for vedic_2bit. Each table row is the input
// set driven before one rising edge and the outputs expected just after it.
// Build with +define+VEDIC_CHECK_EN to also exercise the err output.
`timescale 1ns/1ps
module tb_vedic_2bit;
  import vedic_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  vedic_op_t   a;
  vedic_op_t   b;
  logic        out_valid;
  vedic_prod_t c;
`ifdef VEDIC_CHECK_EN
  logic        err;
`endif

  vedic_2bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .c         (c)
`ifdef VEDIC_CHECK_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        in_valid;
    vedic_op_t   a;
    vedic_op_t   b;
    logic        exp_valid;
    vedic_prod_t exp_c;
  } vec_t;

  vec_t vecs[$];
  int   n_vectors;
  int   n_checks;
  int   n_miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic r, input logic iv,
                     input vedic_op_t va, input vedic_op_t vb,
                     input logic ev, input vedic_prod_t ec);
    vec_t v;
    v.name = name; v.rst = r; v.in_valid = iv; v.a = va; v.b = vb;
    v.exp_valid = ev; v.exp_c = ec;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, then sample 1 ns after the next rising edge.
  task automatic apply(input logic r, input logic iv, input vedic_op_t va, input vedic_op_t vb);
    @(negedge clk);
    rst = r; in_valid = iv; a = va; b = vb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sweep_exp[16];
    int pulses;

    n_vectors = 0; n_checks = 0; n_miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

    // Reset held 3 cycles with a live operand pair: nothing may leak through.
    for (int i = 0; i < 3; i++) add("reset_hold", 1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 4'd0);

    // Exhaustive back-to-back sweep, a-major; expected products written out.
    sweep_exp = '{0,0,0,0, 0,1,2,3, 0,2,4,6, 0,3,6,9};
    for (int i = 0; i < 16; i++)
      add("sweep", 1'b0, 1'b1, vedic_op_t'(i / 4), vedic_op_t'(i % 4), 1'b1,
          vedic_prod_t'(sweep_exp[i]));

    // Hold: one valid sample then idle with changed operands.
    add("hold_load",  1'b0, 1'b1, 2'd2, 2'd3, 1'b1, 4'd6);
    add("hold_idle1", 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 4'd6);
    add("hold_idle2", 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 4'd6);

    // Carry path through both half adders.
    add("carry_3x3", 1'b0, 1'b1, 2'd3, 2'd3, 1'b1, 4'b1001);
    add("carry_3x2", 1'b0, 1'b1, 2'd3, 2'd2, 1'b1, 4'd6);
    add("carry_2x2", 1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 4'd4);
    add("zero_a",    1'b0, 1'b1, 2'd0, 2'd3, 1'b1, 4'd0);

    // Reset mid-stream: second pair coincides with rst and is discarded.
    add("mid_1x3",    1'b0, 1'b1, 2'd1, 2'd3, 1'b1, 4'd3);
    add("mid_rst",    1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 4'd0);
    add("mid_idle",   1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 4'd0);
    add("mid_3x1",    1'b0, 1'b1, 2'd3, 2'd1, 1'b1, 4'd3);
    add("mid_after",  1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'd3);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].in_valid, vecs[i].a, vecs[i].b);
      n_vectors++;
      check({vecs[i].name, ".c"}, 32'(c), 32'(vecs[i].exp_c));
      check({vecs[i].name, ".out_valid"}, 32'(out_valid), 32'(vecs[i].exp_valid));
`ifdef VEDIC_CHECK_EN
      check({vecs[i].name, ".err"}, 32'(err), 32'd0);
`endif
    end

    // Single sample followed by idle cycles: exactly one out_valid pulse.
    apply(1'b0, 1'b1, 2'd1, 2'd2);
    n_vectors++;
    pulses = int'(out_valid);
    check("pulse.c", 32'(c), 32'd2);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 2'd3, 2'd3);
      n_vectors++;
      pulses += int'(out_valid);
      check("pulse.c_hold", 32'(c), 32'd2);
    end
    check("pulse.count", 32'(pulses), 32'd1);

`ifdef VEDIC_CHECK_EN
    // Corrupt bit 0 of the structural product: err must rise with out_valid.
    force dut.w_p0 = ~dut.w_q0;
    apply(1'b0, 1'b1, 2'd1, 2'd1);
    n_vectors++;
    check("force.err", 32'(err), 32'd1);
    check("force.out_valid", 32'(out_valid), 32'd1);
    release dut.w_p0;
    apply(1'b0, 1'b0, 2'd1, 2'd1);
    n_vectors++;
    check("force.err_clear", 32'(err), 32'd0);
    apply(1'b0, 1'b1, 2'd3, 2'd3);
    n_vectors++;
    check("force.err_release", 32'(err), 32'd0);
    check("force.c_release", 32'(c), 32'd9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule : tb_vedic_2bit
